// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer.
//   seq_state_t       : sequencer FSM states
//   NOP_INSTR_DEFAULT : word presented on instr_o while nothing is being issued
//   *_LSB / *_W       : instruction field layout, used by stimulus encoders
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } seq_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 4;
    localparam int RD_LSB  = 4;
    localparam int RD_W    = 5;
    localparam int RB_LSB  = 9;
    localparam int RB_W    = 5;
    localparam int RA_LSB  = 14;
    localparam int RA_W    = 5;
    localparam int OFF_LSB = 19;
    localparam int OFF_W   = 13;

endpackage

// File: rtl/instr_seq_mem.sv
// Program buffer for the instruction sequencer: DEPTH x WIDTH register array,
// one synchronous write port, one asynchronous read port, no reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module instr_seq_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: loads up to DEPTH instruction words, then issues them
// in order over a valid/ready stream (one-shot or looping), with abort and
// progress status.
//   clk_i, rst_ni                   : clock, async active-low reset
//   wr_valid_i/wr_ready_o/wr_data_i : program load stream (IDLE only)
//   clear_i                         : empty the program buffer (IDLE only)
//   start_i, loop_i                 : begin a run; loop_i sampled at start
//   stop_i                          : abort a run
//   instr_o/instr_valid_o/instr_ready_i : issue stream, pc_o = buffer index
//   busy_o, done_o, issue_cnt_o     : status
// Optional feature macro SEQ_BRANCH_EN adds br_valid_i / br_target_i: a branch
// taken on a handshake redirects the next entry; an out-of-range target ends
// the run.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH = 16,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int CNT_WIDTH = 16,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [INSTR_WIDTH-1:0] wr_data_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic                   loop_i,
    input  logic                   stop_i,
`ifdef SEQ_BRANCH_EN
    input  logic                   br_valid_i,
    input  logic [PW-1:0]          br_target_i,
`endif
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [PW-1:0]          pc_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CNT_WIDTH-1:0]   issue_cnt_o
);

    localparam logic [PW:0]          COUNT_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [PW-1:0]        PC_ONE    = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    seq_state_t             state_q, state_d;
    logic [PW:0]            count_q, count_d;
    logic [PW-1:0]          pc_q, pc_d;
    logic                   loop_q, loop_d;
    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [CNT_WIDTH-1:0]   issue_cnt_q, issue_cnt_d;

    logic                   wr_en;
    logic                   hs;
    logic                   last;
    logic [INSTR_WIDTH-1:0] rd_data;

    // DEPTH is a power of two, so the count MSB alone means "buffer full".
    assign wr_ready_o = (state_q == IDLE) && !count_q[PW];
    assign hs         = valid_q && instr_ready_i;
    assign last       = ({1'b0, pc_q} == (count_q - COUNT_ONE));

    instr_seq_mem #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (count_q[PW-1:0]),
        .wdata_i (wr_data_i),
        .raddr_i (pc_d),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pc_d        = pc_q;
        loop_d      = loop_q;
        valid_d     = valid_q;
        issue_cnt_d = issue_cnt_q;
        wr_en       = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (clear_i) begin
                    count_d = '0;
                end else begin
                    if (wr_valid_i && !count_q[PW]) begin
                        wr_en   = 1'b1;
                        count_d = count_q + COUNT_ONE;
                    end
                    if (start_i) begin
                        if (count_q != '0) begin
                            loop_d      = loop_i;
                            pc_d        = '0;
                            issue_cnt_d = '0;
                            valid_d     = 1'b1;
                            state_d     = RUN;
                        end else begin
                            state_d = FINISH;
                        end
                    end
                end
            end

            RUN: begin
                if (hs && (issue_cnt_q != '1)) begin
                    issue_cnt_d = issue_cnt_q + CNT_ONE;
                end
                if (stop_i) begin
                    valid_d = 1'b0;
                    state_d = FINISH;
                end
`ifdef SEQ_BRANCH_EN
                else if (hs && br_valid_i) begin
                    if ({1'b0, br_target_i} >= count_q) begin
                        valid_d = 1'b0;
                        state_d = FINISH;
                    end else begin
                        pc_d = br_target_i;
                    end
                end
`endif
                else if (hs) begin
                    if (!last) begin
                        pc_d = pc_q + PC_ONE;
                    end else if (loop_q) begin
                        pc_d = '0;
                    end else begin
                        valid_d = 1'b0;
                        state_d = FINISH;
                    end
                end
            end

            FINISH: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Read address is pc_d, so the word for the next presented entry is
    // registered together with pc; a stall keeps pc_d == pc_q and holds it.
    assign instr_d = valid_d ? rd_data : NOP_INSTR;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            count_q     <= '0;
            pc_q        <= '0;
            loop_q      <= 1'b0;
            valid_q     <= 1'b0;
            instr_q     <= NOP_INSTR;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pc_q        <= pc_d;
            loop_q      <= loop_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign pc_o          = pc_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == FINISH);
    assign issue_cnt_o   = issue_cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a program model (queue of accepted
// words) generates the expected issue stream into a scoreboard queue; a
// negedge monitor pops and compares on every issue handshake.
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int IW    = 32;
    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = 16;
    localparam logic [IW-1:0] NOP = 32'hF000_000F;

    logic           clk_i, rst_ni;
    logic           wr_valid_i, wr_ready_o;
    logic [IW-1:0]  wr_data_i;
    logic           clear_i, start_i, loop_i, stop_i;
    logic [IW-1:0]  instr_o;
    logic           instr_valid_o, instr_ready_i;
    logic [PW-1:0]  pc_o;
    logic           busy_o, done_o;
    logic [CW-1:0]  issue_cnt_o;
`ifdef SEQ_BRANCH_EN
    logic           br_valid_i = 1'b0;
    logic [PW-1:0]  br_target_i = '0;
`endif

    instr_sequencer #(
        .INSTR_WIDTH (IW),
        .DEPTH       (DEPTH),
        .NOP_INSTR   (NOP),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .wr_data_i     (wr_data_i),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .loop_i        (loop_i),
        .stop_i        (stop_i),
`ifdef SEQ_BRANCH_EN
        .br_valid_i    (br_valid_i),
        .br_target_i   (br_target_i),
`endif
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .pc_o          (pc_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .issue_cnt_o   (issue_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IW-1:0] w;
        logic [PW-1:0] pc;
    } exp_t;

    exp_t          exp_q[$];
    logic [IW-1:0] prog[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            done_cnt = 0;
    int            valid_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    logic          prev_stall = 1'b0;
    logic [IW-1:0] prev_instr;
    logic [PW-1:0] prev_pc;
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (done_o) done_cnt++;
            if (instr_valid_o) begin
                valid_cnt++;
                if (prev_stall) begin
                    check("stall_instr", instr_o, prev_instr);
                    check("stall_pc", pc_o, prev_pc);
                end
                if (instr_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_issue: got instr %0h pc %0d expected no issue", instr_o, pc_o);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("issue_instr", instr_o, e.w);
                        check("issue_pc", pc_o, e.pc);
                    end
                end
            end else begin
                check("nop_out", instr_o, NOP);
            end
            prev_stall = instr_valid_o && !instr_ready_i;
            prev_instr = instr_o;
            prev_pc    = pc_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb,
                                        input logic [12:0] off);
        logic [31:0] w;
        w = '0;
        w[OPC_LSB +: OPC_W] = op;
        w[RD_LSB +: RD_W]   = rd;
        w[RA_LSB +: RA_W]   = ra;
        w[RB_LSB +: RB_W]   = rb;
        w[OFF_LSB +: OFF_W] = off;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_word(input logic [IW-1:0] w);
        wr_valid_i = 1'b1;
        wr_data_i  = w;
        check("wr_ready", wr_ready_o, prog.size() < DEPTH);
        if (prog.size() < DEPTH) prog.push_back(w);
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic clear_prog();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        prog.delete();
    endtask

    // Expected stream for n handshakes: entries in order, wrapping modulo length.
    task automatic push_expect(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.w  = prog[i % prog.size()];
            e.pc = PW'(i % prog.size());
            exp_q.push_back(e);
        end
    endtask

    task automatic start_run(input logic lp);
        loop_i  = lp;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input bit rnd);
        int i;
        i = 0;
        while (!done_o && i < max_cyc) begin
            if (rnd) instr_ready_i = ($urandom_range(0, 3) != 0);
            tick();
            i++;
        end
        n_cmp++;
        if (!done_o) begin
            n_err++;
            $display("FAIL done_timeout: done_o=0 after %0d cycles, expected 1", i);
        end
        instr_ready_i = 1'b1;
        tick();
        check("queue_drained", exp_q.size(), 0);
        check("idle_after_run", busy_o, 0);
    endtask

    initial begin
        int d0, v0, len;
        logic [IW-1:0] w0, w1, w2;

        rst_ni = 1'b0;
        wr_valid_i = 1'b0; wr_data_i = '0; clear_i = 1'b0; start_i = 1'b0;
        loop_i = 1'b0; stop_i = 1'b0; instr_ready_i = 1'b1;
        #12;
        check("rst_instr", instr_o, NOP);
        check("rst_valid", instr_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_cnt", issue_cnt_o, 0);
        check("rst_pc", pc_o, 0);
        check("rst_wr_ready", wr_ready_o, 1);
        rst_ni = 1'b1;
        tick();

        // One-shot ADD/SUB/MUL, ready held high, latency and throughput
        w0 = enc(4'h1, 5'd1, 5'd2, 5'd3, 13'd0);
        w1 = enc(4'h2, 5'd4, 5'd1, 5'd2, 13'd5);
        w2 = enc(4'h3, 5'd7, 5'd4, 5'd4, 13'd100);
        clear_prog();
        write_word(w0); write_word(w1); write_word(w2);
        push_expect(3);
        d0 = done_cnt;
        start_run(1'b0);
        check("lat1_valid", instr_valid_o, 1);
        check("lat1_instr", instr_o, w0);
        tick();
        check("seq_instr1", instr_o, w1);
        tick();
        check("seq_instr2", instr_o, w2);
        tick();
        check("end_valid", instr_valid_o, 0);
        check("end_done", done_o, 1);
        tick();
        check("oneshot_cnt", issue_cnt_o, 3);
        check("oneshot_done_pulses", done_cnt - d0, 1);
        check("oneshot_drained", exp_q.size(), 0);

        // Same program, 4-cycle stall on entry 1
        push_expect(3);
        d0 = done_cnt;
        start_run(1'b0);
        tick();
        instr_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stall_pc1", pc_o, 1);
            check("stall_w1", instr_o, w1);
            tick();
        end
        instr_ready_i = 1'b1;
        wait_done(20, 1'b0);
        check("stall_cnt", issue_cnt_o, 3);
        check("stall_done_pulses", done_cnt - d0, 1);

        // Loop mode, 7 handshakes, stop on the 7th
        clear_prog();
        write_word(32'hA5A5_0001); write_word(32'h5A5A_0002);
        push_expect(7);
        d0 = done_cnt;
        start_run(1'b1);
        repeat (6) tick();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("stop_valid", instr_valid_o, 0);
        check("stop_done", done_o, 1);
        tick();
        check("loop_cnt", issue_cnt_o, 7);
        check("loop_drained", exp_q.size(), 0);
        check("loop_done_pulses", done_cnt - d0, 1);
        check("cnt_holds_idle", issue_cnt_o, 7);

        // Overfill: DEPTH+2 writes, last two dropped
        clear_prog();
        for (int i = 0; i < DEPTH + 2; i++) write_word($urandom);
        check("full_ready", wr_ready_o, 0);
        push_expect(DEPTH);
        start_run(1'b0);
        wait_done(DEPTH * 8 + 20, 1'b1);
        check("full_cnt", issue_cnt_o, DEPTH);

        // Empty start
        clear_prog();
        v0 = valid_cnt;
        d0 = done_cnt;
        start_run(1'b0);
        check("empty_done", done_o, 1);
        check("empty_valid", instr_valid_o, 0);
        tick();
        check("empty_no_valid", valid_cnt - v0, 0);
        check("empty_done_pulses", done_cnt - d0, 1);

        // clear beats write, clear beats start
        write_word(32'h1111_1111); write_word(32'h2222_2222);
        clear_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = 32'h3333_3333;
        tick();
        clear_i = 1'b0; wr_valid_i = 1'b0;
        prog.delete();
        write_word(32'h4444_4444);
        clear_i = 1'b1; start_i = 1'b1;
        tick();
        clear_i = 1'b0; start_i = 1'b0;
        prog.delete();
        check("clear_beats_start", busy_o, 0);
        write_word(32'h5555_5555);
        push_expect(1);
        start_run(1'b0);
        wait_done(20, 1'b0);
        check("clear_write_cnt", issue_cnt_o, 1);

        // Randomized one-shot programs with random ready
        for (int it = 0; it < 15; it++) begin
            clear_prog();
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) write_word($urandom);
            push_expect(len);
            d0 = done_cnt;
            start_run(1'b0);
            wait_done(len * 8 + 20, 1'b1);
            check("rand_cnt", issue_cnt_o, len);
            check("rand_done_pulses", done_cnt - d0, 1);
        end

        // Async reset mid-run
        clear_prog();
        for (int i = 0; i < 4; i++) write_word($urandom);
        push_expect(4);
        start_run(1'b0);
        tick();
        #2;
        rst_ni = 1'b0;
        d0 = done_cnt;
        #1;
        check("mrst_instr", instr_o, NOP);
        check("mrst_valid", instr_valid_o, 0);
        check("mrst_busy", busy_o, 0);
        check("mrst_done", done_o, 0);
        check("mrst_cnt", issue_cnt_o, 0);
        check("mrst_pc", pc_o, 0);
        check("mrst_wr_ready", wr_ready_o, 1);
        exp_q.delete();
        prog.delete();
        #3;
        rst_ni = 1'b1;
        tick();
        check("mrst_no_done", done_cnt - d0, 0);
        v0 = valid_cnt;
        d0 = done_cnt;
        start_run(1'b0);
        tick();
        check("mrst_empty_valid", valid_cnt - v0, 0);
        check("mrst_empty_done", done_cnt - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
